// File: rtl/aiq_steer_if.sv
// Dispatch-side bundle between rename, the steering controller and the AIQ banks.
// master drives the rename/bank inputs; slave is the steering controller.
interface aiq_steer_if #(
  parameter int NUM_BANKS = 2,
  parameter int CW        = 4
);
  logic                      in_valid;
  logic                      in_is_arith;
  logic                      ext_stall;
  logic                      if_recall;
  logic [NUM_BANKS-1:0]      bank_issue;
  logic [NUM_BANKS*CW-1:0]   bank_count;
  logic [NUM_BANKS-1:0]      bank_we;
  logic                      dispatch_stall;
  logic                      busy_recover;
  logic [31:0]               stall_cycles;

  modport master (
    output in_valid, in_is_arith, ext_stall, if_recall, bank_issue, bank_count,
    input  bank_we, dispatch_stall, busy_recover, stall_cycles
  );

  modport slave (
    input  in_valid, in_is_arith, ext_stall, if_recall, bank_issue, bank_count,
    output bank_we, dispatch_stall, busy_recover, stall_cycles
  );
endinterface

// File: rtl/aiq_steer_ctrl.sv
// Steers arithmetic dispatch into NUM_BANKS issue-queue banks using per-bank credit counters.
// Define AIQ_STEER_LEAST_OCC_EN to select the least-occupied bank instead of round-robin.
module aiq_steer_ctrl #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_SIZE = 8,
  parameter int CW        = $clog2(BANK_SIZE) + 1
) (
  input logic        clk,
  input logic        reset,
  aiq_steer_if.slave bus
);
  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // state  | meaning
  // RUN    | normal dispatch; counters follow writes and issues
  // RECALL | banks apply the flush mask; no dispatch
  // RELOAD | counters load bank_count; no dispatch
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_RECALL = 2'd1;
  localparam logic [1:0] S_RELOAD = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CW-1:0]        count [NUM_BANKS];
  logic [PW-1:0]        rr_ptr;
  logic [31:0]          stall_cycles;
  logic [NUM_BANKS-1:0] credit;
  logic                 any_credit;
  logic                 found;
  logic [PW-1:0]        sel;
  logic                 req;
  logic                 run;
  logic                 accept;
  logic [NUM_BANKS-1:0] bank_we;
  logic                 dispatch_stall;

  always_comb begin
    credit = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      credit[b] = (count[b] < CW'(BANK_SIZE));
  end
  assign any_credit = |credit;

`ifdef AIQ_STEER_LEAST_OCC_EN
  logic [CW-1:0] best;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    best  = '0;
    // strict less-than keeps the lowest index on ties
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (credit[b] && (!found || count[b] < best)) begin
        sel   = PW'(b);
        best  = count[b];
        found = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] idx;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_BANKS);
      if (!found && credit[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  assign req    = bus.in_valid & bus.in_is_arith;
  assign run    = (state == S_RUN);
  assign accept = ~reset & req & found & run & ~bus.ext_stall & ~bus.if_recall;

  always_comb begin
    bank_we = '0;
    if (accept) bank_we[sel] = 1'b1;
  end

  assign dispatch_stall = bus.ext_stall |
                          (~reset & req & (~any_credit | ~run | bus.if_recall));

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (bus.if_recall) state_nxt = S_RECALL;
      S_RECALL: state_nxt = bus.if_recall ? S_RECALL : S_RELOAD;
      S_RELOAD: state_nxt = bus.if_recall ? S_RECALL : S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      rr_ptr       <= '0;
      stall_cycles <= '0;
      for (int b = 0; b < NUM_BANKS; b++) count[b] <= '0;
    end else begin
      state <= state_nxt;
      if (dispatch_stall) stall_cycles <= stall_cycles + 32'd1;
      if (accept) rr_ptr <= (sel == PW'(NUM_BANKS - 1)) ? '0 : sel + 1'b1;
      // issues during recovery are ignored; the reload value is authoritative
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (state == S_RELOAD) begin
          count[b] <= bus.bank_count[b*CW +: CW];
        end else if (run) begin
          if (bank_we[b] && !bus.bank_issue[b] && count[b] != CW'(BANK_SIZE))
            count[b] <= count[b] + 1'b1;
          else if (!bank_we[b] && bus.bank_issue[b] && count[b] != '0)
            count[b] <= count[b] - 1'b1;
        end
      end
    end
  end

  assign bus.bank_we        = bank_we;
  assign bus.dispatch_stall = dispatch_stall;
  assign bus.busy_recover   = ~run;
  assign bus.stall_cycles   = stall_cycles;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_chk
    a_no_issue_empty: assert property (@(posedge clk) disable iff (reset)
      (run && bus.bank_issue[g] && !bank_we[g]) |-> (count[g] != '0));
    a_no_write_full: assert property (@(posedge clk) disable iff (reset)
      (run && bank_we[g] && !bus.bank_issue[g]) |-> (count[g] != CW'(BANK_SIZE)));
  end
endmodule
